serial_alu_n: RTL and testbench

SERIAL_ALU_N -- requirements
Module: serial_alu_n

---
 rtl/alu_pkg.sv | 38 +++
 rtl/serial_regfile.sv | 49 ++++
 rtl/serial_alu_n.sv | 161 ++++++++++++++++
 tb/tb_serial_alu_n.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings and op-class bit positions for the serial ALU.
package alu_pkg;

    localparam int OP_BITS = 4;

    // Class bits are meaningful only when OP_LOGIC_BIT is clear (arithmetic group).
    localparam int OP_CARRY_BIT = 0;
    localparam int OP_SUB_BIT   = 1;
    localparam int OP_NOWB_BIT  = 2;
    localparam int OP_LOGIC_BIT = 3;

    typedef enum logic [OP_BITS-1:0] {
        OP_ADD = 4'b0000,
        OP_ADC = 4'b0001,
        OP_SUB = 4'b0010,
        OP_SBC = 4'b0011,
        OP_CMP = 4'b0110,
        OP_AND = 4'b1000,
        OP_OR  = 4'b1001,
        OP_XOR = 4'b1010,
        OP_MOV = 4'b1011,
        OP_SHL = 4'b1100,
        OP_RLC = 4'b1101
    } alu_op_e;

    // Turns (length - 1) into the mask of register-index bits the byte index replaces.
    function automatic int unsigned len_mask(input int unsigned m1);
        int unsigned r;
        r = m1;
        r = r | (r >> 1);
        r = r | (r >> 2);
        r = r | (r >> 4);
        r = r | (r >> 8);
        r = r | (r >> 16);
        return r;
    endfunction

endpackage

// File: rtl/serial_regfile.sv
// Register file scanned NSHIFT bits per cycle: each enabled register rotates right,
// port 1 inserting write data at the top, port 2 recirculating its own low chunk.
module serial_regfile
    import alu_pkg::*;
#(
    parameter int LOG2_NR  = 3,
    parameter int REG_BITS = 8,
    parameter int NSHIFT   = 2
) (
    input  logic               clk,
    input  logic               en1,
    input  logic [LOG2_NR-1:0] addr1,
    input  logic [NSHIFT-1:0]  wdata1,
    output logic [NSHIFT-1:0]  rdata1,
    input  logic               en2,
    input  logic [LOG2_NR-1:0] addr2,
    output logic [NSHIFT-1:0]  rdata2
);

    localparam int NR = 1 << LOG2_NR;

    logic [REG_BITS-1:0] regs [NR];
    logic [NR-1:0]       we1;
    logic [NR-1:0]       we2;

    always_comb begin
        we1 = '0;
        we2 = '0;
        for (int i = 0; i < NR; i++) begin
            we1[i] = en1 && (addr1 == LOG2_NR'(i));
            we2[i] = en2 && (addr2 == LOG2_NR'(i)) && !we1[i];
        end
    end

    // When both ports address one register, port 1 owns the rotation.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (we1[i]) begin
                regs[i] <= REG_BITS'({wdata1, regs[i]} >> NSHIFT);
            end else if (we2[i]) begin
                regs[i] <= REG_BITS'({regs[i], regs[i]} >> NSHIFT);
            end
        end
    end

    assign rdata1 = regs[addr1][NSHIFT-1:0];
    assign rdata2 = regs[addr2][NSHIFT-1:0];

endmodule

// File: rtl/serial_alu_n.sv
// Multi-register serial ALU processing NSHIFT bits per cycle, LSB chunk first.
// Define SERIAL_ALU_SHIFT_EN to enable SHL/RLC; otherwise they act as MOV.
module serial_alu_n
    import alu_pkg::*;
#(
    parameter int LOG2_NR   = 3,
    parameter int REG_BITS  = 8,
    parameter int NSHIFT    = 2,
    parameter int MAX_BYTES = 4,
    localparam int NBW = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1,
    localparam int CW  = (MAX_BYTES * REG_BITS / NSHIFT > 1) ?
                         $clog2(MAX_BYTES * REG_BITS / NSHIFT) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               op_valid,
    output logic               op_done,
    output logic               active,
    input  logic [OP_BITS-1:0] operation,
    input  logic [NBW-1:0]     nbytes_m1,
    input  logic [LOG2_NR-1:0] reg1,
    input  logic [LOG2_NR-1:0] reg2,
    input  logic               external_arg2,
    input  logic               update_reg1,
    input  logic               update_carry_flags,
    input  logic               update_other_flags,
    input  logic [NSHIFT-1:0]  data_in2,
    output logic [NSHIFT-1:0]  data_out,
    output logic               flag_c,
    output logic               flag_v,
    output logic               flag_s,
    output logic               flag_z,
    output logic [CW-1:0]      counter
);

    localparam int CPB     = REG_BITS / NSHIFT;
    localparam int CPB_LOG = $clog2(CPB);
    localparam int SW      = NSHIFT + 1;

    logic [CW-1:0]      last_cnt;
    logic               first;
    logic [LOG2_NR-1:0] byte_idx;
    logic [LOG2_NR-1:0] lmask;
    logic [LOG2_NR-1:0] addr1;
    logic [LOG2_NR-1:0] addr2;
    logic [NSHIFT-1:0]  a1;
    logic [NSHIFT-1:0]  rd2;
    logic [NSHIFT-1:0]  a2;
    logic [NSHIFT-1:0]  b;
    logic [NSHIFT-1:0]  wdata;
    logic [NSHIFT-1:0]  res;
    logic [SW-1:0]      sum;
    logic               is_arith;
    logic               carry_use;
    logic               subtract;
    logic               no_wb;
    logic               cin;
    logic               cout;
    logic               vout;
    logic               carry_q;

    assign last_cnt = CW'((32'(nbytes_m1) + 32'd1) * 32'(CPB) - 32'd1);
    assign active   = op_valid;
    assign op_done  = op_valid && (counter == last_cnt);
    assign first    = (counter == '0);

    // Byte k of an operand lives at the base register with its length bits replaced by k.
    assign byte_idx = LOG2_NR'(32'(counter) >> CPB_LOG);
    assign lmask    = LOG2_NR'(len_mask(32'(nbytes_m1)));
    assign addr1    = (reg1 & ~lmask) | (byte_idx & lmask);
    assign addr2    = (reg2 & ~lmask) | (byte_idx & lmask);

    assign is_arith  = !operation[OP_LOGIC_BIT];
    assign carry_use = is_arith && operation[OP_CARRY_BIT];
    assign subtract  = is_arith && operation[OP_SUB_BIT];
    assign no_wb     = is_arith && operation[OP_NOWB_BIT];

    assign a2  = external_arg2 ? data_in2 : rd2;
    assign b   = subtract ? ~a2 : a2;
    assign cin = first ? (carry_use ? flag_c : subtract) : carry_q;
    assign sum = {1'b0, a1} + {1'b0, b} + SW'(cin);

`ifdef SERIAL_ALU_SHIFT_EN
    logic          shift_q;
    logic          sin;
    logic [SW-1:0] shl_wide;

    assign sin      = first ? ((operation == OP_RLC) && flag_c) : shift_q;
    assign shl_wide = {a1, sin};
`endif

    always_comb begin
        res  = sum[NSHIFT-1:0];
        cout = sum[NSHIFT];
        vout = (a1[NSHIFT-1] == b[NSHIFT-1]) && (sum[NSHIFT-1] != a1[NSHIFT-1]);
        case (operation)
            OP_AND: res = a1 & a2;
            OP_OR:  res = a1 | a2;
            OP_XOR: res = a1 ^ a2;
            OP_MOV: res = a2;
`ifdef SERIAL_ALU_SHIFT_EN
            OP_SHL, OP_RLC: begin
                res  = shl_wide[NSHIFT-1:0];
                cout = shl_wide[NSHIFT];
                vout = 1'b0;
            end
`else
            OP_SHL, OP_RLC: res = a2;
`endif
            default: ;
        endcase
    end

    assign data_out = res;
    // Destination always rotates so it realigns after a full operation, even without write-back.
    assign wdata    = (update_reg1 && !no_wb) ? res : a1;

    serial_regfile #(
        .LOG2_NR (LOG2_NR),
        .REG_BITS(REG_BITS),
        .NSHIFT  (NSHIFT)
    ) u_regfile (
        .clk   (clk),
        .en1   (active),
        .addr1 (addr1),
        .wdata1(wdata),
        .rdata1(a1),
        .en2   (active && !external_arg2),
        .addr2 (addr2),
        .rdata2(rd2)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            counter <= '0;
            carry_q <= 1'b0;
            flag_c  <= 1'b0;
            flag_v  <= 1'b0;
            flag_s  <= 1'b0;
            flag_z  <= 1'b0;
`ifdef SERIAL_ALU_SHIFT_EN
            shift_q <= 1'b0;
`endif
        end else if (active) begin
            counter <= op_done ? '0 : counter + CW'(1);
            carry_q <= sum[NSHIFT];
`ifdef SERIAL_ALU_SHIFT_EN
            shift_q <= a1[NSHIFT-1];
`endif
            if (update_carry_flags) begin
                flag_c <= cout;
                flag_v <= vout;
            end
            if (update_other_flags) begin
                flag_s <= res[NSHIFT-1];
                flag_z <= (res == '0) && (flag_z || first);
            end
        end
    end

endmodule

// File: tb/tb_serial_alu_n.sv
// Randomized bench for serial_alu_n against an operand-level model of the register file.
module tb_serial_alu_n;
    import alu_pkg::*;

    logic       clk;
    logic       reset;
    logic       op_valid;
    logic       op_done;
    logic       active;
    logic [3:0] operation;
    logic [1:0] nbytes_m1;
    logic [2:0] reg1;
    logic [2:0] reg2;
    logic       external_arg2;
    logic       update_reg1;
    logic       update_carry_flags;
    logic       update_other_flags;
    logic [1:0] data_in2;
    logic [1:0] data_out;
    logic       flag_c;
    logic       flag_v;
    logic       flag_s;
    logic       flag_z;
    logic [3:0] counter;

    serial_alu_n dut (
        .clk               (clk),
        .reset             (reset),
        .op_valid          (op_valid),
        .op_done           (op_done),
        .active            (active),
        .operation         (operation),
        .nbytes_m1         (nbytes_m1),
        .reg1              (reg1),
        .reg2              (reg2),
        .external_arg2     (external_arg2),
        .update_reg1       (update_reg1),
        .update_carry_flags(update_carry_flags),
        .update_other_flags(update_other_flags),
        .data_in2          (data_in2),
        .data_out          (data_out),
        .flag_c            (flag_c),
        .flag_v            (flag_v),
        .flag_s            (flag_s),
        .flag_z            (flag_z),
        .counter           (counter)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model state and scoreboard ----------------
    logic [7:0] mregs [8];
    bit         mflag_c, mflag_v, mflag_s, mflag_z;
    logic [6:0] exp_q [$];   // {op_done, counter, data_out}
    int         n_checks;
    int         n_errors;
    int         last_done_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] gather(input int base, input int nb);
        logic [63:0] v;
        v = '0;
        for (int k = 0; k <= nb; k++) v = v | (64'(mregs[base + k]) << (8 * k));
        return v;
    endfunction

    function automatic bit is_arith_op(input logic [3:0] op);
        bit r;
        r = (op == OP_ADD) || (op == OP_ADC) || (op == OP_SUB) || (op == OP_SBC) || (op == OP_CMP);
`ifdef SERIAL_ALU_SHIFT_EN
        r = r || (op == OP_SHL) || (op == OP_RLC);
`endif
        return r;
    endfunction

    // Compare process: every active cycle consumes one expected chunk.
    always @(negedge clk) begin
        logic [6:0] e;
        if (!reset) begin
            check("active", 64'(active), 64'(op_valid));
            if (op_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_active", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("data_out", 64'(data_out), 64'(e[1:0]));
                    check("counter", 64'(counter), 64'(e[5:2]));
                    check("op_done", 64'(op_done), 64'(e[6]));
                    if (op_done) last_done_cnt = int'(counter);
                end
            end else begin
                check("idle_op_done", 64'(op_done), 64'd0);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic run_op(input logic [3:0] op, input int nb, input int r1, input int r2,
                          input bit ext, input logic [31:0] ev, input bit upd,
                          input bit ucf, input bit uof, input int pause_at,
                          input int pause_len, output logic [31:0] cap);
        int          w, l;
        logic [63:0] mask, a, b, bb, full, res;
        bit          c, v, sin;
        w    = (nb + 1) * 8;
        l    = (nb + 1) * 4;
        mask = (64'd1 << w) - 64'd1;
        a    = gather(r1, nb);
        b    = ext ? (64'(ev) & mask) : gather(r2, nb);
        c    = mflag_c;
        v    = mflag_v;
        sin  = 1'b0;
        case (op)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CMP: begin
                bb   = (op == OP_SUB || op == OP_SBC || op == OP_CMP) ? (~b & mask) : b;
                full = a + bb + ((op == OP_ADC || op == OP_SBC) ? 64'(mflag_c) :
                                 ((op == OP_ADD) ? 64'd0 : 64'd1));
                res  = full & mask;
                c    = full[w];
                v    = (a[w-1] == bb[w-1]) && (res[w-1] != a[w-1]);
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
`ifdef SERIAL_ALU_SHIFT_EN
            OP_SHL, OP_RLC: begin
                sin = (op == OP_RLC) && mflag_c;
                res = ((a << 1) | 64'(sin)) & mask;
                c   = a[w-1];
                v   = 1'b0;
            end
`endif
            default: res = b;
        endcase

        for (int i = 0; i < l; i++)
            exp_q.push_back({(i == l - 1), 4'(i), 2'(res >> (2 * i))});

        cap = '0;
        for (int i = 0; i < l; i++) begin
            if (i == pause_at) begin
                op_valid = 1'b0;
                repeat (pause_len) begin
                    @(negedge clk);
                    check("pause_counter", 64'(counter), 64'(pause_at));
                    @(posedge clk);
                    #1;
                end
            end
            op_valid           = 1'b1;
            operation          = op;
            nbytes_m1          = 2'(nb);
            reg1               = 3'(r1);
            reg2               = 3'(r2);
            external_arg2      = ext;
            update_reg1        = upd;
            update_carry_flags = ucf;
            update_other_flags = uof;
            data_in2           = 2'(ev >> (2 * i));
            @(negedge clk);
            cap = cap | (32'(data_out) << (2 * i));
            @(posedge clk);
            #1;
        end
        op_valid = 1'b0;

        if (upd && op != OP_CMP)
            for (int k = 0; k <= nb; k++) mregs[r1 + k] = 8'(res >> (8 * k));
        if (ucf) begin
            mflag_c = c;
            mflag_v = v;
        end
        if (uof) begin
            mflag_s = res[w-1];
            mflag_z = (res == 64'd0);
        end

        @(negedge clk);
        check("flag_c", 64'(flag_c), 64'(mflag_c));
        check("flag_v", 64'(flag_v), 64'(mflag_v));
        check("flag_s", 64'(flag_s), 64'(mflag_s));
        check("flag_z", 64'(flag_z), 64'(mflag_z));
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int base, input int nb, input logic [31:0] val);
        logic [31:0] cap;
        run_op(OP_MOV, nb, base, 0, 1'b1, val, 1'b1, 1'b0, 1'b0, -1, 0, cap);
    endtask

    task automatic read_reg(input int base, input int nb, output logic [31:0] val);
        run_op(OP_OR, nb, base, 0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, -1, 0, val);
    endtask

    task automatic load_all();
        load(0, 3, $urandom);
        load(4, 3, $urandom);
    endtask

    // ---------------- stimulus ----------------
    logic [3:0]  op_list [11];
    logic [31:0] cap;
    logic [63:0] sa;

    initial begin
        n_checks = 0;
        n_errors = 0;
        last_done_cnt = -1;
        op_list = '{OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CMP, OP_AND, OP_OR, OP_XOR,
                    OP_MOV, OP_SHL, OP_RLC};
        for (int i = 0; i < 8; i++) mregs[i] = '0;
        {mflag_c, mflag_v, mflag_s, mflag_z} = '0;
        reset = 1'b1;
        op_valid = 1'b0;
        operation = OP_ADD;
        nbytes_m1 = '0;
        reg1 = '0;
        reg2 = '0;
        external_arg2 = 1'b0;
        update_reg1 = 1'b0;
        update_carry_flags = 1'b0;
        update_other_flags = 1'b0;
        data_in2 = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_counter", 64'(counter), 64'd0);
        check("rst_flags", 64'({flag_c, flag_v, flag_s, flag_z}), 64'd0);
        check("rst_op_done", 64'(op_done), 64'd0);
        @(posedge clk);
        #1;

        load_all();

        // 8-bit ADD
        load(0, 0, 32'h34);
        load(1, 0, 32'h12);
        run_op(OP_ADD, 0, 0, 1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1, -1, 0, cap);
        check("add8_result", 64'(cap), 64'h46);
        check("add8_done_cnt", 64'(last_done_cnt), 64'd3);
        check("add8_flags_czs", 64'({flag_c, flag_z, flag_s}), 64'd0);
        read_reg(0, 0, cap);
        check("add8_r0", 64'(cap), 64'h46);

        // 16-bit ADD with carry across bytes
        load(0, 1, 32'h00FF);
        load(2, 1, 32'h0001);
        run_op(OP_ADD, 1, 0, 2, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1, -1, 0, cap);
        check("add16_result", 64'(cap), 64'h0100);
        check("add16_done_cnt", 64'(last_done_cnt), 64'd7);
        check("add16_flags_cz", 64'({flag_c, flag_z}), 64'd0);

        // CMP equal, then 32-bit ADC wrap
        load(4, 0, 32'h05);
        load(5, 0, 32'h05);
        run_op(OP_CMP, 0, 4, 5, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1, -1, 0, cap);
        check("cmp_flags_zc", 64'({flag_z, flag_c}), 64'b11);
        read_reg(4, 0, cap);
        check("cmp_r4_kept", 64'(cap), 64'h05);
        load(0, 3, 32'hFFFF_FFFF);
        run_op(OP_ADC, 3, 0, 0, 1'b1, 32'd0, 1'b1, 1'b1, 1'b1, -1, 0, cap);
        check("adc32_result", 64'(cap), 64'd0);
        check("adc32_flags_cz", 64'({flag_c, flag_z}), 64'b11);
        check("adc32_done_cnt", 64'(last_done_cnt), 64'd15);

        // Shift encodings
        load(0, 0, 32'h81);
`ifdef SERIAL_ALU_SHIFT_EN
        run_op(OP_SHL, 0, 0, 1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, -1, 0, cap);
        check("shl_result", 64'(cap), 64'h02);
        check("shl_c", 64'(flag_c), 64'd1);
        run_op(OP_RLC, 0, 0, 1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, -1, 0, cap);
        check("rlc_result", 64'(cap), 64'h05);
        check("rlc_c", 64'(flag_c), 64'd0);
`else
        run_op(OP_SHL, 0, 0, 1, 1'b1, 32'h3C, 1'b1, 1'b0, 1'b0, -1, 0, cap);
        check("shl_as_mov", 64'(cap), 64'h3C);
        read_reg(0, 0, cap);
        check("shl_as_mov_r0", 64'(cap), 64'h3C);
`endif

        // Pause mid-operation versus uninterrupted
        load(0, 1, 32'h1234);
        load(2, 1, 32'h0F0F);
        run_op(OP_ADD, 1, 0, 2, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, -1, 0, cap);
        check("nopause_result", 64'(cap), 64'h2143);
        run_op(OP_ADD, 1, 0, 2, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 3, 2, cap);
        check("pause_result", 64'(cap), 64'h2143);
        read_reg(0, 1, cap);
        check("pause_r0", 64'(cap), 64'h2143);

        // Reset at counter 2 of a 16-bit ADD
        load(0, 1, 32'hFFFF);
        load(2, 1, 32'h0003);
        sa = gather(0, 1) + gather(2, 1);
        for (int i = 0; i < 2; i++) exp_q.push_back({1'b0, 4'(i), 2'(sa >> (2 * i))});
        operation = OP_ADD;
        nbytes_m1 = 2'd1;
        reg1 = 3'd0;
        reg2 = 3'd2;
        external_arg2 = 1'b0;
        update_reg1 = 1'b1;
        update_carry_flags = 1'b1;
        update_other_flags = 1'b1;
        op_valid = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_counter_before", 64'(counter), 64'd2);
        @(posedge clk);
        #1;
        reset = 1'b0;
        op_valid = 1'b0;
        exp_q.delete();
        {mflag_c, mflag_v, mflag_s, mflag_z} = '0;
        @(negedge clk);
        check("rst_mid_counter", 64'(counter), 64'd0);
        check("rst_mid_flags", 64'({flag_c, flag_v, flag_s, flag_z}), 64'd0);
        check("rst_mid_op_done", 64'(op_done), 64'd0);
        @(posedge clk);
        #1;
        load_all();
        load(0, 0, 32'h10);
        load(1, 0, 32'h20);
        run_op(OP_ADD, 0, 0, 1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1, -1, 0, cap);
        check("post_rst_add", 64'(cap), 64'h30);
        check("post_rst_done_cnt", 64'(last_done_cnt), 64'd3);

        // Randomized operations
        for (int n = 0; n < 60; n++) begin
            logic [3:0] op;
            int nb, align, r1, r2, pat, plen;
            bit ext, ucf;
            op    = op_list[$urandom_range(0, 10)];
            nb    = $urandom_range(0, 3);
            align = (nb == 0) ? 1 : ((nb == 1) ? 2 : 4);
            r1    = $urandom_range(0, 8 / align - 1) * align;
            r2    = $urandom_range(0, 8 / align - 1) * align;
            ext   = 1'($urandom_range(0, 1));
            ucf   = is_arith_op(op) ? 1'($urandom_range(0, 1)) : 1'b0;
            pat   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, (nb + 1) * 4 - 1) : -1;
            plen  = $urandom_range(1, 3);
            run_op(op, nb, r1, r2, ext, $urandom, 1'($urandom_range(0, 1)), ucf,
                   1'($urandom_range(0, 1)), pat, plen, cap);
        end
        for (int r = 0; r < 8; r += 4) begin
            read_reg(r, 3, cap);
            check("final_regs", 64'(cap), gather(r, 3));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
